// File: rtl/rr_arb_mux.sv
// rr_arb_mux -- N-channel round-robin arbiter feeding a single registered
// output slot (valid/ready on both sides).
//
// Build option: define RR_ARB_MUX_FIXED_PRIO_EN to replace round-robin with
// fixed lowest-index-first priority in auto mode. Manual mode is the same in
// both builds.
//
// Ports
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   in_data       N*WIDTH payloads, channel i at [i*WIDTH +: WIDTH]
//   in_valid      per-channel offer valid
//   in_ready      per-channel accept (one-hot or zero)
//   sel_force_en  1 = manual mode (arbitration disabled)
//   sel_force     channel index used in manual mode
//   out_data      registered payload
//   out_valid     output slot holds a word
//   out_ready     downstream accept
//   out_sel       channel index of the payload in out_data

// Per-channel accept: a channel is accepted only when it holds the grant
// and the output slot can take a word this cycle.
module rr_arb_mux_lane #(
    parameter int IDX  = 0,
    parameter int SELW = 1
) (
    input  logic            can_load,
    input  logic            gnt_vld,
    input  logic [SELW-1:0] gnt_idx,
    output logic            ready
);
    assign ready = can_load && gnt_vld && (gnt_idx == SELW'(IDX));
endmodule

module rr_arb_mux #(
    parameter int  WIDTH = 4,
    parameter int  N     = 4,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 sel_force_en,
    input  logic [SELW-1:0]      sel_force,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [N-1:0][WIDTH-1:0]  ch_data;
    logic                     gnt_vld;
    logic [SELW-1:0]          gnt_idx;
    logic                     can_load;
    logic                     load;

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
    // Index of the most recent auto-mode winner; search starts one above it.
    logic [SELW-1:0]          last_q;
    int                       idx;
`endif

    assign ch_data   = in_data;
    assign out_valid = (state_q == FULL);

    // Slot is free, or the current word leaves this cycle. Gating with rst
    // keeps every in_ready low while reset is held.
    assign can_load  = !rst && ((state_q == EMPTY) || (out_valid && out_ready));
    assign load      = can_load && gnt_vld;

    // Grant selection. Loops run high-to-low so the highest-priority hit is
    // the last assignment and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
        idx     = 0;
`endif
        if (sel_force_en) begin
            // Out-of-range sel_force matches no channel, so no grant.
            for (int i = 0; i < N; i++) begin
                if (sel_force == SELW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
`else
            // Offset k=1 (last+1) is highest priority, k=N (last itself) lowest.
            for (int k = N; k >= 1; k--) begin
                idx = (int'(last_q) + k) % N;
                if (in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(idx);
                end
            end
`endif
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            rr_arb_mux_lane #(
                .IDX  (g),
                .SELW (SELW)
            ) u_lane (
                .can_load (can_load),
                .gnt_vld  (gnt_vld),
                .gnt_idx  (gnt_idx),
                .ready    (in_ready[g])
            );
        end
    endgenerate

    // Output slot FSM: a load always leaves it FULL (covers drain+load with
    // no bubble); a drain without a load empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load) state_d = FULL;
            FULL:    if (out_ready && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Payload register holds its value across a drain; only a load or reset
    // changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
            last_q   <= SELW'(N - 1);
`endif
        end else if (load) begin
            out_data <= ch_data[gnt_idx];
            out_sel  <= gnt_idx;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
            if (!sel_force_en) last_q <= gnt_idx;
`endif
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic        sel_force_en;
    logic [1:0]  sel_force;
    logic        out_ready;

    logic [3:0]  in_ready4;
    logic [3:0]  out_data4;
    logic        out_valid4;
    logic [1:0]  out_sel4;

    logic [2:0]  in_ready3;
    logic [3:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_sel3;

    int checks = 0;
    int errors = 0;

    // Reference state, index 0 = 4-channel DUT, 1 = 3-channel DUT.
    int m_full[2], m_data[2], m_sel[2], m_last[2], m_g[2];
    int nch[2] = '{4, 3};

    rr_arb_mux #(.WIDTH(4), .N(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .sel_force_en(sel_force_en), .sel_force(sel_force),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_sel(out_sel4)
    );

    rr_arb_mux #(.WIDTH(4), .N(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[11:0]), .in_valid(in_valid[2:0]),
        .in_ready(in_ready3), .sel_force_en(sel_force_en), .sel_force(sel_force),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .out_sel(out_sel3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Winning channel under the arbitration rules, -1 if none.
    function automatic int pick(int n, logic [3:0] v, logic man, int sf, int last);
        int order[$];
        if (man) return (sf < n && v[sf]) ? sf : -1;
        if (FP) begin
            for (int c = 0; c < n; c++) order.push_back(c);
        end else begin
            for (int k = 0; k < n; k++) order.push_back((last + 1 + k) % n);
        end
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    // One clock: check in_ready mid-cycle, advance model on the edge, check outputs.
    task automatic cyc();
        logic [3:0] v;
        int         g;
        bit         can;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            v   = (d == 1) ? {1'b0, in_valid[2:0]} : in_valid;
            g   = pick(nch[d], v, sel_force_en, int'(sel_force), m_last[d]);
            can = (m_full[d] == 0) || out_ready;
            m_g[d] = (!rst && can) ? g : -1;
            chk(d ? "rdy3" : "rdy4", d ? {29'd0, in_ready3} : {28'd0, in_ready4},
                (m_g[d] >= 0) ? (32'd1 << m_g[d]) : 32'd0);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_full[d] = 0; m_data[d] = 0; m_sel[d] = 0; m_last[d] = nch[d] - 1;
            end else if (m_g[d] >= 0) begin
                m_full[d] = 1;
                m_data[d] = int'((in_data >> (4 * m_g[d])) & 16'hf);
                m_sel[d]  = m_g[d];
                if (!sel_force_en && !FP) m_last[d] = m_g[d];
            end else if (m_full[d] != 0 && out_ready) begin
                m_full[d] = 0;
            end
        end
        #1;
        chk("vld4", {31'd0, out_valid4}, m_full[0]);
        chk("dat4", {28'd0, out_data4}, m_data[0]);
        chk("sel4", {30'd0, out_sel4}, m_sel[0]);
        chk("vld3", {31'd0, out_valid3}, m_full[1]);
        chk("dat3", {28'd0, out_data3}, m_data[1]);
        chk("sel3", {30'd0, out_sel3}, m_sel[1]);
    endtask

    initial begin
        int seq4[5] = '{0, 1, 2, 3, 0};
        int seq3[5] = '{0, 1, 2, 0, 1};
        int alt[4]  = '{1, 3, 1, 3};
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 0; m_data[d] = 0; m_sel[d] = 0; m_last[d] = nch[d] - 1; m_g[d] = -1;
        end
        rst = 1'b1; in_data = 16'h0; in_valid = 4'hf; sel_force_en = 1'b0;
        sel_force = 2'd0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_vld", {31'd0, out_valid4}, 32'd0);
        chk("rst_rdy", {28'd0, in_ready4}, 32'd0);

        // Release with all channels offering: rotating grants, no bubble.
        rst = 1'b0; in_data = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr_vld", {31'd0, out_valid4}, 32'd1);
            chk("rr_sel4", {30'd0, out_sel4}, FP ? 32'd0 : seq4[i]);
            chk("rr_sel3", {30'd0, out_sel3}, FP ? 32'd0 : seq3[i]);
        end

        // Sparse valids 1010.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("alt_sel", {30'd0, out_sel4}, FP ? 32'd1 : alt[i]);
        end

        // Load 0xA from channel 2 in auto mode, then stall downstream.
        in_valid = 4'b0100; in_data = 16'h0A00;
        cyc();
        in_valid = 4'b1111; in_data = 16'h7654; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_dat", {28'd0, out_data4}, 32'hA);
            chk("hold_sel", {30'd0, out_sel4}, 32'd2);
            chk("hold_rdy", {28'd0, in_ready4}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_rdy", {28'd0, in_ready4}, FP ? 32'b0001 : 32'b1000);
        cyc();

        // Manual mode on a non-valid channel, then on a valid one.
        sel_force_en = 1'b1; sel_force = 2'd2; in_valid = 4'b0011;
        cyc(); cyc();
        chk("man_none", {31'd0, out_valid4}, 32'd0);
        in_valid = 4'b0111; in_data = 16'h0500;
        cyc();
        chk("man_dat", {28'd0, out_data4}, 32'h5);
        chk("man_sel", {30'd0, out_sel4}, 32'd2);
        sel_force_en = 1'b0; in_valid = 4'b1111; in_data = 16'h4321;
        cyc();
        chk("man_last", {30'd0, out_sel4}, 32'd0);

        // sel_force beyond N-1 on the 3-channel instance.
        sel_force_en = 1'b1; sel_force = 2'd3;
        #1;
        chk("n3_oor", {29'd0, in_ready3}, 32'd0);
        cyc();
        sel_force_en = 1'b0;

        // Reset while holding a stalled word.
        out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_vld", {31'd0, out_valid4}, 32'd0);
        chk("mid_rst_dat", {28'd0, out_data4}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        cyc();
        chk("post_rst_sel", {30'd0, out_sel4}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(49) == 0);
            in_valid     = 4'($urandom);
            in_data      = 16'($urandom);
            out_ready    = ($urandom_range(3) != 0);
            sel_force_en = ($urandom_range(7) == 0);
            sel_force    = 2'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
